// File: rtl/alu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// alu_pipe_ctrl
//
// Sequencer for an 8-bit pipelined ALU datapath. It fetches 16-bit
// instructions over a valid/ready handshake and decodes them into ALU op,
// register addresses and immediate. It tracks a two-stage pipeline (EX, then
// WB), drives the register-file write enable and the forwarding select, and
// runs a halt/drain state machine.
//
// Instruction format:
//   [15:14] op  : 00 ADDI, 01 SLLI, 10 NOP, 11 HALT
//   [13:11] rd  : destination register
//   [10:8]  rs  : source register
//   [7:0]   imm : immediate
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   instr_req     out  fetch request at pc (RUN and not stalled)
//   pc            out  fetch address, PC_W bits
//   instr_valid   in   instr is valid this cycle
//   instr         in   16-bit instruction word
//   stall         in   external hold; freezes every stage
//   rs_ex         out  register-file read address of the EX instruction
//   imm_ex        out  immediate of the EX instruction
//   alu_op_ex     out  0 = add, 1 = shift-left
//   rd_wb         out  write-back destination register
//   reg_write_wb  out  register-file write enable
//   fwd_sel       out  1 = take the ALU operand from the write-back data
//   halted        out  pipeline drained after HALT
//   retire_cnt    out  16-bit count of write-back cycles
//                      (only when ALU_PIPE_CTRL_RETIRE_CNT_EN is defined)
//
// Parameters:
//   PC_W      program counter width
//   RESET_PC  pc value loaded on reset
//
// Optional feature macro: ALU_PIPE_CTRL_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module alu_pipe_ctrl #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  input  logic            stall,
  output logic [2:0]      rs_ex,
  output logic [7:0]      imm_ex,
  output logic            alu_op_ex,
  output logic [2:0]      rd_wb,
  output logic            reg_write_wb,
  output logic            fwd_sel,
  output logic            halted
`ifdef ALU_PIPE_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]     retire_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADDI = 2'b00,
    OP_SLLI = 2'b01,
    OP_NOP  = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
  } instr_t;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;

  logic [PC_W-1:0] pc_q, pc_d;

  // EX stage
  logic            ex_valid_q, ex_valid_d;
  logic [2:0]      rs_ex_q, rs_ex_d;
  logic [2:0]      rd_ex_q, rd_ex_d;
  logic [7:0]      imm_ex_q, imm_ex_d;
  logic            alu_op_ex_q, alu_op_ex_d;

  // WB stage
  logic            wb_valid_q, wb_valid_d;
  logic [2:0]      rd_wb_q, rd_wb_d;

  instr_t          dec;
  logic            accept;
  logic            dec_writes;
  logic            halt_accept;

  assign dec = instr_t'(instr);

  // Only ADDI and SLLI produce a register result; NOP and HALT enter EX as
  // bubbles.
  assign dec_writes  = (dec.op == OP_ADDI) || (dec.op == OP_SLLI);

  // instr_req already excludes stall, so an accept never coincides with one.
  assign accept      = instr_req && instr_valid;
  assign halt_accept = accept && (dec.op == OP_HALT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every variable assigned here first so no path can infer a
    // latch.
    state_d = state_q;
    if (!stall) begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_RUN;
        ST_RUN:    if (halt_accept) state_d = ST_DRAIN;
        // Decide on the stage contents after this edge, so halted rises two
        // cycles after the HALT accept rather than three.
        ST_DRAIN:  if (!ex_valid_d && !wb_valid_d) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_req = (state_q == ST_RUN) && !stall;
    halted    = (state_q == ST_HALTED);
  end

  // ---------------------------------------------------------------------------
  // Pipeline next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    ex_valid_d  = ex_valid_q;
    rs_ex_d     = rs_ex_q;
    rd_ex_d     = rd_ex_q;
    imm_ex_d    = imm_ex_q;
    alu_op_ex_d = alu_op_ex_q;
    wb_valid_d  = wb_valid_q;
    rd_wb_d     = rd_wb_q;

    if (!stall) begin
      // EX -> WB advances on every non-stalled edge.
      wb_valid_d = ex_valid_q;
      rd_wb_d    = rd_ex_q;

      // Fetch -> EX: a bubble unless a register-writing instruction is taken.
      ex_valid_d = accept && dec_writes;

      if (accept) begin
        pc_d        = pc_q + PC_W'(1);
        rs_ex_d     = dec.rs;
        rd_ex_d     = dec.rd;
        imm_ex_d    = dec.imm;
        alu_op_ex_d = (dec.op == OP_SLLI);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ex_valid_q  <= 1'b0;
      rs_ex_q     <= '0;
      rd_ex_q     <= '0;
      imm_ex_q    <= '0;
      alu_op_ex_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      rd_wb_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      ex_valid_q  <= ex_valid_d;
      rs_ex_q     <= rs_ex_d;
      rd_ex_q     <= rd_ex_d;
      imm_ex_q    <= imm_ex_d;
      alu_op_ex_q <= alu_op_ex_d;
      wb_valid_q  <= wb_valid_d;
      rd_wb_q     <= rd_wb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc        = pc_q;
  assign rs_ex     = rs_ex_q;
  assign imm_ex    = imm_ex_q;
  assign alu_op_ex = alu_op_ex_q;
  assign rd_wb     = rd_wb_q;

  // WB holds its instruction through a stall; gating the enable keeps the
  // register file from writing the same result on every stalled cycle.
  assign reg_write_wb = wb_valid_q && !stall;

  // The EX operand is the register the WB instruction is about to write, so
  // the register file would return the stale value.
  assign fwd_sel = ex_valid_q && wb_valid_q && (rs_ex_q == rd_wb_q);

`ifdef ALU_PIPE_CTRL_RETIRE_CNT_EN
  // ---------------------------------------------------------------------------
  // Retire counter: one count per write-back cycle, wraps at 16 bits. It holds
  // through stalls and HALTED because reg_write_wb is 0 there.
  // ---------------------------------------------------------------------------
  logic [15:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (reg_write_wb) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
